// File: rtl/stopwatch_ctrl_if.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl_if
//
// Purpose: groups every non-clock signal of the stopwatch controller into one
// bundle shared by the controller, the counter chain and the display path.
//
// Signals:
//   tick_100hz  1   one-clk-wide 100 Hz enable pulse (clk domain)
//   btn_ss      1   raw start/stop button, asynchronous, active-high
//   btn_lr      1   raw lap/reset button, asynchronous, active-high
//   cnt_value   24  live BCD chain value {min1,min0,sec1,sec0,cs1,cs0}
//   count_en    1   count enable to the least-significant chain digit
//   clear       1   one-cycle synchronous clear to the chain
//   disp_value  24  value to display (lap snapshot in LAP, else cnt_value)
//   lap_num     4   BCD lap count, saturates at 9
//   state       2   IDLE=00, RUN=01, PAUSE=10, LAP=11
//   overflow    1   sticky auto-stop flag (0 when auto-stop is not built)
//
// Modports:
//   master  the environment: drives buttons, tick and chain value
//   slave   the controller:  drives enable, clear, display and status
// ----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    logic        tick_100hz;
    logic        btn_ss;
    logic        btn_lr;
    logic [23:0] cnt_value;
    logic        count_en;
    logic        clear;
    logic [23:0] disp_value;
    logic [3:0]  lap_num;
    logic [1:0]  state;
    logic        overflow;

    modport master (
        output tick_100hz, btn_ss, btn_lr, cnt_value,
        input  count_en, clear, disp_value, lap_num, state, overflow
    );

    modport slave (
        input  tick_100hz, btn_ss, btn_lr, cnt_value,
        output count_en, clear, disp_value, lap_num, state, overflow
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Purpose: control FSM for a 6-digit cascaded BCD stopwatch chain (MM:SS.cc).
// Conditions the start/stop and lap/reset buttons (2-flop synchronizer plus
// debounce), gates the chain's count enable from the 100 Hz tick, issues the
// chain clear pulse and holds a lap snapshot for the display mux.
//
// Ports:
//   clk   system clock, single domain
//   rst   asynchronous, active-high reset
//   bus   stopwatch_ctrl_if.slave (tick, buttons, chain value in;
//         count_en, clear, disp_value, lap_num, state, overflow out)
//
// Parameters:
//   DB_CYCLES  cycles a synchronized button level must be stable to be accepted
//   DB_W       debounce counter width, 2**DB_W > DB_CYCLES
//
// Optional build macro: STOPWATCH_AUTOSTOP_EN
//   Defined   : the run stops at 59:59.99 (count_en forced low, FSM moves to
//               PAUSE, sticky overflow set; start/stop ignored until reset).
//   Undefined : no compare logic, overflow tied 0, the chain wraps freely.
// ----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 20,
    parameter int DB_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    // The counter indexes mismatch cycles from 0, so reaching DB_CYCLES-1
    // while still mismatched means DB_CYCLES stable cycles have been seen.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Bit 0 = start/stop, bit 1 = lap/reset
    logic [1:0]      meta_q;
    logic [1:0]      sync_q;
    logic [1:0]      acc_q;
    logic [1:0]      acc_d;
    logic [1:0]      press_q;
    logic [1:0]      press_d;
    logic [DB_W-1:0] dbc_q [2];
    logic [DB_W-1:0] dbc_d [2];

    logic            ss_p;
    logic            lr_p;

    state_t          state_q;
    state_t          state_d;
    logic [23:0]     lap_q;
    logic [23:0]     lap_d;
    logic [3:0]      lapn_q;
    logic [3:0]      lapn_d;
    logic            clear_q;
    logic            clear_d;
    logic            run_like;
    logic            ss_blocked;

`ifdef STOPWATCH_AUTOSTOP_EN
    localparam logic [23:0] CNT_MAX = 24'h595999;
    logic            ovf_q;
    logic            ovf_d;
    logic            at_max;
`endif

    function automatic logic [3:0] bcd_inc_sat(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd9 : d + 4'd1;
    endfunction

    // ------------------------------------------------------------------
    // Button synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= {bus.btn_lr, bus.btn_ss};
            sync_q <= meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: count consecutive cycles where the synchronized level
    // differs from the accepted level; any return to agreement restarts
    // the count. The press pulse is produced together with the accepted
    // rising edge, so releases generate nothing.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            acc_d[i]   = acc_q[i];
            press_d[i] = 1'b0;
            dbc_d[i]   = '0;
            if (sync_q[i] != acc_q[i]) begin
                if (dbc_q[i] == DB_LAST) begin
                    acc_d[i]   = sync_q[i];
                    press_d[i] = sync_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= 2'b00;
            press_q  <= 2'b00;
            dbc_q[0] <= '0;
            dbc_q[1] <= '0;
        end else begin
            acc_q    <= acc_d;
            press_q  <= press_d;
            dbc_q[0] <= dbc_d[0];
            dbc_q[1] <= dbc_d[1];
        end
    end

    assign ss_p = press_q[0];
    assign lr_p = press_q[1];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign run_like = (state_q == S_RUN) || (state_q == S_LAP);

`ifdef STOPWATCH_AUTOSTOP_EN
    assign at_max     = run_like && (bus.cnt_value == CNT_MAX);
    // After an auto-stop only lap/reset may leave PAUSE
    assign ss_blocked = ovf_q;
`else
    assign ss_blocked = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        lapn_d  = lapn_q;
        clear_d = 1'b0;
`ifdef STOPWATCH_AUTOSTOP_EN
        ovf_d   = ovf_q;
`endif

        // Start/stop is tested first in every state, so it wins a tie.
        unique case (state_q)
            S_IDLE: begin
                if (ss_p) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ss_p) begin
                    state_d = S_PAUSE;
                end else if (lr_p) begin
                    state_d = S_LAP;
                    lap_d   = bus.cnt_value;
                    lapn_d  = bcd_inc_sat(lapn_q);
                end
            end
            S_LAP: begin
                if (ss_p) begin
                    state_d = S_PAUSE;
                end else if (lr_p) begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (ss_p && !ss_blocked) begin
                    state_d = S_RUN;
                end else if (lr_p) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                    lapn_d  = 4'd0;
                    lap_d   = 24'd0;
`ifdef STOPWATCH_AUTOSTOP_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
        endcase

`ifdef STOPWATCH_AUTOSTOP_EN
        // Reaching the top value overrides any press in the same cycle
        if (at_max) begin
            state_d = S_PAUSE;
            lap_d   = lap_q;
            lapn_d  = lapn_q;
            ovf_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lap_q   <= 24'd0;
            lapn_q  <= 4'd0;
            clear_q <= 1'b0;
`ifdef STOPWATCH_AUTOSTOP_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
            lapn_q  <= lapn_d;
            clear_q <= clear_d;
`ifdef STOPWATCH_AUTOSTOP_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
`ifdef STOPWATCH_AUTOSTOP_EN
    assign bus.count_en = bus.tick_100hz && run_like && !at_max;
    assign bus.overflow = ovf_q;
`else
    assign bus.count_en = bus.tick_100hz && run_like;
    assign bus.overflow = 1'b0;
`endif

    assign bus.clear      = clear_q;
    assign bus.disp_value = (state_q == S_LAP) ? lap_q : bus.cnt_value;
    assign bus.lap_num    = lapn_q;
    assign bus.state      = state_q;

endmodule
